// File: rtl/moving_average_filter.sv
// Multi-channel moving-average filter with a power-of-two window (2**k samples).
// Each channel keeps its own history RAM, write pointer and running accumulator.
// A flush sweep clears all history after reset or whenever the window exponent changes.
// Optional macro MOVAVG_ROUND_EN: round half up on the final shift instead of flooring.
module moving_average_filter #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned MAX_LOG2_LEN = 4,
    parameter int unsigned CHANNELS     = 2,
    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned K_W  = $clog2(MAX_LOG2_LEN + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         write,
    input  logic [CH_W-1:0]              channel,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic [K_W-1:0]               log2_len,
    output logic                         ready,
    output logic                         done,
    output logic [CH_W-1:0]              done_channel,
    output logic signed [DATA_WIDTH-1:0] sum
);

    localparam int unsigned DEPTH = 2 ** MAX_LOG2_LEN;
    localparam int unsigned ACC_W = DATA_WIDTH + MAX_LOG2_LEN;
    localparam logic [MAX_LOG2_LEN:0] SPAN_ONE = 1;

    typedef enum logic {StFlush, StRun} state_e;

    state_e                         r_state;
    state_e                         w_state_d;
    logic [MAX_LOG2_LEN-1:0]        r_flush_addr;
    logic [K_W-1:0]                 r_len;
    logic                           r_done;
    logic [CH_W-1:0]                r_done_ch;
    logic signed [DATA_WIDTH-1:0]   r_sum;

    logic signed [ACC_W-1:0]        r_hist [CHANNELS][DEPTH];
    logic signed [ACC_W-1:0]        r_acc  [CHANNELS];
    logic [MAX_LOG2_LEN-1:0]        r_ptr  [CHANNELS];

    logic                           w_ch_ok;
    logic [CH_W-1:0]                w_ch_idx;
    logic                           w_accept;
    logic                           w_len_change;
    logic [K_W-1:0]                 w_k;
    logic [MAX_LOG2_LEN-1:0]        w_old_idx;
    logic signed [ACC_W-1:0]        w_x;
    logic signed [ACC_W-1:0]        w_acc_new;
    logic signed [DATA_WIDTH-1:0]   w_sum_d;
`ifdef MOVAVG_ROUND_EN
    logic signed [ACC_W:0]          w_one;
    logic signed [ACC_W:0]          w_half;
    logic signed [ACC_W:0]          w_rnd;
`endif

    assign ready        = (r_state == StRun);
    assign done         = r_done;
    assign done_channel = r_done_ch;
    assign sum          = r_sum;

    // Next-state: sweep every history address once, then run until the window changes
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StFlush: if (&r_flush_addr) w_state_d = StRun;
            StRun:   if (w_len_change) w_state_d = StFlush;
            default: w_state_d = StFlush;
        endcase
    end

    // Datapath: accept decision and the single-cycle accumulator update
    always_comb begin
        w_ch_ok      = 32'(channel) < CHANNELS;
        w_ch_idx     = w_ch_ok ? channel : '0;
        w_accept     = write && ready && w_ch_ok;
        w_len_change = ready && (log2_len != r_len);
        // Writes in the cycle that changes the exponent still use the old (registered) k
        w_k          = (r_len > K_W'(MAX_LOG2_LEN)) ? K_W'(MAX_LOG2_LEN) : r_len;
        // For k = MAX_LOG2_LEN the span wraps to 0, so the outgoing sample is the slot
        // about to be overwritten
        w_old_idx    = r_ptr[w_ch_idx] - MAX_LOG2_LEN'(SPAN_ONE << w_k);
        w_x          = {{MAX_LOG2_LEN{data_in[DATA_WIDTH-1]}}, data_in};
        w_acc_new    = r_acc[w_ch_idx] - r_hist[w_ch_idx][w_old_idx] + w_x;
`ifdef MOVAVG_ROUND_EN
        // Half is zero when k = 0, which leaves the plain truncation
        w_one        = 1;
        w_half       = (w_one << w_k) >> 1;
        w_rnd        = {w_acc_new[ACC_W-1], w_acc_new} + w_half;
        w_sum_d      = DATA_WIDTH'(w_rnd >>> w_k);
`else
        w_sum_d      = DATA_WIDTH'(w_acc_new >>> w_k);
`endif
    end

    // Control and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= StFlush;
            r_flush_addr <= '0;
            r_len        <= '0;
            r_done       <= 1'b0;
            r_done_ch    <= '0;
            r_sum        <= '0;
        end else begin
            r_state <= w_state_d;
            r_done  <= w_accept;
            if (r_state == StFlush) begin
                r_len        <= log2_len;
                r_flush_addr <= r_flush_addr + 1'b1;
            end else if (w_len_change) begin
                r_len        <= log2_len;
                r_flush_addr <= '0;
            end
            if (w_accept) begin
                r_sum     <= w_sum_d;
                r_done_ch <= channel;
            end
        end
    end

    // Per-channel history, accumulator and pointer; cleared by the flush sweep
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (r_state == StFlush) begin
                for (int c = 0; c < int'(CHANNELS); c++) begin
                    r_hist[c][r_flush_addr] <= '0;
                    r_acc[c]                <= '0;
                    r_ptr[c]                <= '0;
                end
            end else if (w_accept) begin
                r_hist[w_ch_idx][r_ptr[w_ch_idx]] <= w_x;
                r_acc[w_ch_idx]                   <= w_acc_new;
                r_ptr[w_ch_idx]                   <= r_ptr[w_ch_idx] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_moving_average_filter.sv
// Self-checking bench for moving_average_filter: directed scenarios plus randomized traffic
// checked against a window-sum model over a log of accepted samples.
module tb_moving_average_filter;

    localparam int DW  = 16;
    localparam int ML  = 4;
    localparam int CHN = 3;
    localparam int CHW = 2;
    localparam int KW  = 3;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 write = 1'b0;
    logic [CHW-1:0]       channel = '0;
    logic signed [DW-1:0] data_in = '0;
    logic [KW-1:0]        log2_len = '0;
    logic                 ready;
    logic                 done;
    logic [CHW-1:0]       done_channel;
    logic signed [DW-1:0] sum;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int ch;
        int val;
    } samp_t;
    samp_t          log_q[$];
    logic [DW-1:0]  last_sum = '0;
    logic [CHW-1:0] last_ch = '0;
    int             cur_k = 0;

    moving_average_filter #(
        .DATA_WIDTH  (DW),
        .MAX_LOG2_LEN(ML),
        .CHANNELS    (CHN)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .write       (write),
        .channel     (channel),
        .data_in     (data_in),
        .log2_len    (log2_len),
        .ready       (ready),
        .done        (done),
        .done_channel(done_channel),
        .sum         (sum)
    );

    always #5 clock = ~clock;

    // Average of the last 2**k samples of a channel since the last flush, missing ones = 0
    function automatic logic [DW-1:0] model_avg(input int ch, input int k);
        longint s = 0;
        int n = 0;
        int ke = (k > ML) ? ML : k;
        for (int i = log_q.size() - 1; i >= 0; i--) begin
            if (log_q[i].ch == ch && n < (1 << ke)) begin
                s += longint'(log_q[i].val);
                n++;
            end
        end
`ifdef MOVAVG_ROUND_EN
        if (ke > 0) s += longint'(1) << (ke - 1);
`endif
        s = s >>> ke;
        return DW'(s);
    endfunction

    // One clock of stimulus; records accepted samples and the expected result
    task automatic step(input bit wr, input int ch, input int x, output bit acc);
        logic signed [DW-1:0] xs;
        samp_t s;
        xs = DW'(x);
        write = wr;
        channel = CHW'(ch);
        data_in = xs;
        acc = wr && ready && (ch < CHN);
        @(posedge clock);
        #1;
        write = 1'b0;
        if (acc) begin
            s.ch = ch;
            s.val = int'(xs);
            log_q.push_back(s);
            last_sum = model_avg(ch, cur_k);
            last_ch = CHW'(ch);
        end
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!ready && cycles < 200) begin
            @(posedge clock);
            #1;
            cycles++;
        end
    endtask

    task automatic apply_reset(input int k);
        int c;
        log2_len = KW'(k);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        log_q.delete();
        last_sum = '0;
        last_ch = '0;
        cur_k = k;
        wait_ready(c);
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready_timeout: ready=%b after %0d cycles, required 1", ready, c);
        end
    endtask

    task automatic test_reset();
        int cnt;
        int noisy;
        log2_len = 3'd2;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++;
        if (ready !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: ready=%b done=%b, required 0 0", ready, done);
        end
        n_cmp++;
        if (sum !== '0 || done_channel !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: sum=%0d ch=%0d, required 0 0", sum, done_channel);
        end
        reset = 1'b0;
        cnt = 0;
        noisy = 0;
        while (!ready && cnt < 100) begin
            @(posedge clock);
            #1;
            cnt++;
            if (done !== 1'b0 || sum !== '0) noisy++;
        end
        n_cmp++;
        if (cnt !== 16) begin
            n_bad++;
            $display("FAIL reset_ready_latency: got %0d cycles, required 16", cnt);
        end
        n_cmp++;
        if (noisy !== 0) begin
            n_bad++;
            $display("FAIL reset_quiet: %0d cycles with done/sum nonzero, required 0", noisy);
        end
        log_q.delete();
        cur_k = 2;
    endtask

    task automatic test_window();
        int vals[5] = '{100, 200, 300, 400, 500};
        int exps[5] = '{25, 75, 150, 250, 350};
        bit a;
        apply_reset(2);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 0, vals[i], a);
            n_cmp++;
            if (done !== 1'b1 || sum !== DW'(exps[i])) begin
                n_bad++;
                $display("FAIL window_k2[%0d]: done=%b sum=%0d, required 1 %0d",
                         i, done, sum, exps[i]);
            end
        end
        step(1'b0, 0, 0, a);
        n_cmp++;
        if (done !== 1'b0 || sum !== 16'sd350) begin
            n_bad++;
            $display("FAIL window_hold: done=%b sum=%0d, required 0 350", done, sum);
        end
    endtask

    task automatic test_interleave();
        bit a;
        int ch;
        apply_reset(1);
        for (int i = 0; i < 8; i++) begin
            ch = i % 2;
            step(1'b1, ch, (ch == 0) ? 1000 : -1000, a);
            n_cmp++;
            if (done !== 1'b1 || done_channel !== CHW'(ch) || sum !== last_sum) begin
                n_bad++;
                $display("FAIL interleave[%0d]: done=%b ch=%0d sum=%0d, required 1 %0d %0d",
                         i, done, done_channel, sum, ch, $signed(last_sum));
            end
        end
    endtask

    task automatic test_saturation();
        bit a;
        apply_reset(4);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1, 32'h7FFF, a);
            n_cmp++;
            if (sum !== last_sum) begin
                n_bad++;
                $display("FAIL sat_pos[%0d]: sum=%h, required %h", i, sum, last_sum);
            end
        end
        n_cmp++;
        if (sum !== 16'h7FFF) begin
            n_bad++;
            $display("FAIL sat_pos_final: sum=%h, required 7fff", sum);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1, 32'h8000, a);
            n_cmp++;
            if (sum !== last_sum) begin
                n_bad++;
                $display("FAIL sat_neg[%0d]: sum=%h, required %h", i, sum, last_sum);
            end
        end
        n_cmp++;
        if (sum !== 16'h8000) begin
            n_bad++;
            $display("FAIL sat_neg_final: sum=%h, required 8000", sum);
        end
    endtask

    task automatic test_rounding();
        bit a;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
        apply_reset(1);
        step(1'b1, 0, 3, a);
`ifdef MOVAVG_ROUND_EN
        e1 = last_sum;
`else
        e1 = 16'd1;
`endif
        n_cmp++;
        if (sum !== e1) begin
            n_bad++;
            $display("FAIL round_first: sum=%0d, required %0d", sum, e1);
        end
        step(1'b1, 0, 0, a);
`ifdef MOVAVG_ROUND_EN
        e2 = last_sum;
`else
        e2 = 16'd1;
`endif
        n_cmp++;
        if (sum !== e2) begin
            n_bad++;
            $display("FAIL round_second: sum=%0d, required %0d", sum, e2);
        end
    endtask

    task automatic test_bad_channel();
        bit a;
        apply_reset(2);
        step(1'b1, 0, 40, a);
        step(1'b1, 3, 999, a);
        n_cmp++;
        if (done !== 1'b0 || sum !== 16'sd10 || done_channel !== 2'd0) begin
            n_bad++;
            $display("FAIL bad_channel_ignored: done=%b sum=%0d ch=%0d, required 0 10 0",
                     done, sum, done_channel);
        end
        step(1'b1, 0, 40, a);
        n_cmp++;
        if (done !== 1'b1 || sum !== 16'sd20) begin
            n_bad++;
            $display("FAIL bad_channel_nostate: done=%b sum=%0d, required 1 20", done, sum);
        end
    endtask

    task automatic test_len_change();
        bit a;
        int cnt;
        apply_reset(2);
        step(1'b1, 0, 20, a);
        step(1'b1, 0, 40, a);
        log2_len = 3'd3;
        step(1'b1, 0, 60, a);
        n_cmp++;
        if (done !== 1'b1 || sum !== last_sum || sum !== 16'sd30) begin
            n_bad++;
            $display("FAIL len_change_old_k: done=%b sum=%0d, required 1 30", done, sum);
        end
        cur_k = 3;
        log_q.delete();
        wait_ready(cnt);
        n_cmp++;
        if (cnt !== 16) begin
            n_bad++;
            $display("FAIL len_change_flush: ready low %0d cycles, required 16", cnt);
        end
        step(1'b1, 0, 80, a);
        n_cmp++;
        if (done !== 1'b1 || sum !== 16'sd10) begin
            n_bad++;
            $display("FAIL len_change_first: done=%b sum=%0d, required 1 10", done, sum);
        end
    endtask

    task automatic test_reset_midrun();
        bit a;
        int cnt;
        apply_reset(3);
        step(1'b1, 1, 300, a);
        step(1'b1, 1, 500, a);
        reset = 1'b1;
        write = 1'b1;
        channel = 2'd1;
        data_in = 16'sd700;
        @(posedge clock);
        #1;
        write = 1'b0;
        reset = 1'b0;
        n_cmp++;
        if (done !== 1'b0 || sum !== '0 || ready !== 1'b0) begin
            n_bad++;
            $display("FAIL midrun_reset: done=%b sum=%0d ready=%b, required 0 0 0",
                     done, sum, ready);
        end
        log_q.delete();
        last_sum = '0;
        last_ch = '0;
        wait_ready(cnt);
        n_cmp++;
        if (cnt !== 16) begin
            n_bad++;
            $display("FAIL midrun_reflush: ready after %0d cycles, required 16", cnt);
        end
        step(1'b1, 1, 800, a);
        n_cmp++;
        if (done !== 1'b1 || sum !== 16'sd100) begin
            n_bad++;
            $display("FAIL midrun_fresh: done=%b sum=%0d, required 1 100", done, sum);
        end
    endtask

    task automatic test_random();
        int ks[3] = '{0, 3, 6};
        bit a;
        bit wr;
        int ch;
        for (int j = 0; j < 3; j++) begin
            apply_reset(ks[j]);
            for (int i = 0; i < 80; i++) begin
                wr = ($urandom_range(0, 9) < 7);
                ch = int'($urandom_range(0, 3));
                step(wr, ch, int'($urandom), a);
                n_cmp++;
                if (a) begin
                    if (done !== 1'b1 || done_channel !== CHW'(ch) || sum !== last_sum) begin
                        n_bad++;
                        $display("FAIL random_k%0d[%0d]: done=%b ch=%0d sum=%h, required 1 %0d %h",
                                 ks[j], i, done, done_channel, sum, ch, last_sum);
                    end
                end else begin
                    if (done !== 1'b0 || done_channel !== last_ch || sum !== last_sum) begin
                        n_bad++;
                        $display("FAIL random_hold_k%0d[%0d]: done=%b ch=%0d sum=%h, required 0 %0d %h",
                                 ks[j], i, done, done_channel, sum, last_ch, last_sum);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_window();
        test_interleave();
        test_saturation();
        test_rounding();
        test_bad_channel();
        test_len_change();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
